dn_spi_tx: RTL and testbench
============================

Name: dn_spi_tx

Overview:
- Downstream stage of the adaptive-filter core.
- Captures each 13-bit filter output sample dn when the core strobes it, and queues samples in a small FIFO.
- Serialises one 16-bit status+sample frame per SPI chip-select window on miso, as an SPI slave in mode 0.
- SPI inputs sck/cs are asynchronous; they are synchronised and edge-detected in the clk domain.

Parameters:
- DW, 13, sample width; frame bits 12:0.
- DEPTH, 8, FIFO entries; must be a power of 2, ≥2.
- SYNC_STAGES, 2, flip-flop stages on sck and cs.

Ports:
- clk  input  1  system clock; must be ≥8× sck frequency.
- rstn  input  1  asynchronous active-low reset.
- dn  input  DW  filter output sample, two's complement.
- dn_vld  input  1  one-cycle strobe; dn is valid this cycle.
- sck  input  1  SPI clock from master; async; idles low.
- cs  input  1  SPI chip select; async; active low.
- miso  output  1  serial data out.
- fifo_cnt  output  $clog2(DEPTH)+1  current occupancy.
- ovf  output  1  sticky: a sample was dropped.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - miso=0, fifo_cnt=0, ovf=0.
  - Shift register=0, bit counter=0, FSM=IDLE.
  - Synchroniser flops reset to idle levels: sck=0, cs=1.
- Push:
  - dn_vld=1 with fifo_cnt<DEPTH writes dn at the write pointer; fifo_cnt increments the next cycle.
  - dn_vld=1 when full drops the sample and sets ovf.
- Simultaneous push and pop:
  - fifo_cnt is unchanged and both are performed, including when full.
  - Because of this, a push when full with a pop in the same cycle is accepted.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Edge detection: cs_fall, cs_rise and sck_fall are taken from the synchronised signals (SYNC_STAGES flops plus one history flop), so latency is SYNC_STAGES+1 clk.
- FSM IDLE:
  - miso=0.
  - On cs_fall, load the frame, pop if non-empty, set bitcnt=0 and go to SHIFT.
  - Frame when FIFO non-empty: bit15=1 (valid), bit14=ovf, bit13=0, bits12:0=FIFO head.
  - Frame when FIFO empty: bit15=0, bit14=ovf, bits13:0=0. No pop.
  - ovf is cleared in the load cycle, because it has been reported. If a drop occurs in that same cycle, ovf stays set.
- FSM SHIFT:
  - miso = shreg[15], so the MSB is valid before the first sck rise.
  - On each sck_fall, shift left (fill 0) and increment bitcnt.
  - When bitcnt reaches 16, go to DONE.
- FSM DONE:
  - miso=0.
  - Further sck edges are ignored.
  - On cs_rise, go to IDLE.
- Abort:
  - cs_rise in SHIFT goes to IDLE at once and sets miso=0.
  - The popped word is lost, and ovf is set.
- cs_fall and cs_rise in the same cycle cannot occur by construction of the edge detector.
- An sck_fall in IDLE is ignored.
- Async reset mid-frame: return immediately to the reset state; FIFO contents are discarded.

Optional Feature:
- Macro: DN_SPI_TX_PARITY_EN.
- Defined:
  - Frame bit13 carries even parity over bits 15:14 and 12:0, so the total count of ones in the 16 bits is even.
  - The idle/empty frame also carries parity; it is 0x0000 or 0x6000 (ovf set).
- Undefined: bit13 is constant 0.

Decomposition:
- Package dn_spi_pkg holds:
  - FRAME_W=16 and bit positions VLD_BIT=15, OVF_BIT=14, PAR_BIT=13.
  - The FSM state enum IDLE/SHIFT/DONE.
  - Function frame_build(vld, ovf, data), including the parity term under the macro.
- One sub-module: dn_sync_fifo, a parameterised DW×DEPTH FIFO with push, pop, rd_data, cnt, full and empty. The top contains the synchronisers, FSM and shifter.

Test Plan:
- Push dn=0x0ABC, then run a 16-sck frame → miso bits = 0x8ABC MSB first (macro off); fifo_cnt 1→0 at cs_fall+3 clk.
- Frame with FIFO empty → 0x0000, fifo_cnt stays 0.
- Push 9 samples 0x0001..0x0009 with DEPTH=8 → fifo_cnt=8 and ovf=1; next frame → 0xC001 and ovf clears; next frame → 0x8002.
- Raise cs after 5 sck falls → miso=0 within 3 clk, FSM=IDLE, ovf=1; next frame carries the next FIFO entry with bit14=1.
- Push and pop in the same cycle while full (cs_fall aligned with dn_vld) → fifo_cnt stays 8, ovf stays 0, 8 frames drain in order.
- Macro on: dn=0x0003 → frame 0x8003 has three ones, so bit13=1 and the frame is 0xA003; empty frame with ovf=1 → 0x6000.

Source files
------------

// File: rtl/dn_spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dn_spi_pkg : frame layout, FSM states and frame builder for dn_spi_tx |
// | Optional: DN_SPI_TX_PARITY_EN puts even parity in frame bit 13.       |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package dn_spi_pkg;

  localparam int FRAME_W = 16;
  localparam int VLD_BIT = 15;
  localparam int OVF_BIT = 14;
  localparam int PAR_BIT = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } dn_state_e;

  // Parity spans every other frame bit so the whole frame has an even count of ones.
  function automatic logic [FRAME_W-1:0] frame_build(input logic vld,
                                                     input logic ovf,
                                                     input logic [PAR_BIT-1:0] data);
    logic [FRAME_W-1:0] f;
    f                = '0;
    f[VLD_BIT]       = vld;
    f[OVF_BIT]       = ovf;
    f[PAR_BIT-1:0]   = data;
`ifdef DN_SPI_TX_PARITY_EN
    f[PAR_BIT]       = ^{vld, ovf, data};
`endif
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dn_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dn_sync_fifo : single-clock DW x DEPTH FIFO, push/pop in same cycle   |
// | allowed (also when full). DEPTH must be a power of two.              |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module dn_sync_fifo #(
  parameter int DW    = 13,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_cnt == CW'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign w_do_pop  = pop & ~empty;
  // When full, the slot being read this cycle is the one being overwritten.
  assign w_do_push = push & (~full | w_do_pop);
  assign rd_data   = r_mem[r_rd_ptr];
  assign cnt       = r_cnt;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dn_spi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dn_spi_tx : queues filter samples and shifts one status+sample frame  |
// | per chip-select window as an SPI mode-0 slave.                        |
// | Optional  : DN_SPI_TX_PARITY_EN (even parity in frame bit 13).        |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module dn_spi_tx
  import dn_spi_pkg::*;
#(
  parameter int DW          = 13,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DW-1:0]           dn,
  input  logic                    dn_vld,
  input  logic                    sck,
  input  logic                    cs,
  output logic                    miso,
  output logic [$clog2(DEPTH):0]  fifo_cnt,
  output logic                    ovf
);

  // SPI inputs: SYNC_STAGES flops (at least 2) plus one history flop each.
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;
  logic                   w_sck_s;
  logic                   w_cs_s;
  logic                   w_sck_fall;
  logic                   w_cs_fall;
  logic                   w_cs_rise;

  dn_state_e              r_state;
  dn_state_e              w_state_nxt;
  logic [FRAME_W-1:0]     r_shreg;
  logic [FRAME_W-1:0]     w_shreg_nxt;
  logic [4:0]             r_bitcnt;
  logic [4:0]             w_bitcnt_nxt;
  logic                   r_ovf;
  logic                   w_load;
  logic                   w_pop;
  logic                   w_abort;
  logic                   w_drop;

  logic [DW-1:0]          w_fifo_rd;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [PAR_BIT-1:0]     w_head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sck_sync <= '0;
      r_cs_sync  <= '1;
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sck_d    <= w_sck_s;
      r_cs_d     <= w_cs_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_fall = r_sck_d & ~w_sck_s;
  assign w_cs_fall  = r_cs_d & ~w_cs_s;
  assign w_cs_rise  = ~r_cs_d & w_cs_s;

  dn_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (dn_vld),
    .din     (dn),
    .pop     (w_pop),
    .rd_data (w_fifo_rd),
    .cnt     (fifo_cnt),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  assign w_head = PAR_BIT'(w_fifo_rd);
  assign w_drop = dn_vld & w_fifo_full & ~w_pop;

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_load       = 1'b1;
          w_pop        = ~w_fifo_empty;
          w_shreg_nxt  = frame_build(~w_fifo_empty, r_ovf,
                                     w_fifo_empty ? '0 : w_head);
          w_bitcnt_nxt = '0;
          w_state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          // Master gave up mid-frame: the popped sample is lost.
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_sck_fall) begin
          w_shreg_nxt  = {r_shreg[FRAME_W-2:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt + 5'd1;
          if (r_bitcnt == 5'(FRAME_W - 1)) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      // A drop in the load cycle must survive the clear of the reported flag.
      r_ovf    <= w_drop | w_abort | (r_ovf & ~w_load);
    end
  end

  assign miso = (r_state == SHIFT) & r_shreg[FRAME_W-1];
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dn_spi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dn_spi_tx : directed self-checking bench for dn_spi_tx             |
// | Expected frames switch with DN_SPI_TX_PARITY_EN.                      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_dn_spi_tx;

  logic        clk;
  logic        rstn;
  logic [12:0] dn;
  logic        dn_vld;
  logic        sck;
  logic        cs;
  logic        miso;
  logic [3:0]  fifo_cnt;
  logic        ovf;

  int n_pass;
  int n_total;

`ifdef DN_SPI_TX_PARITY_EN
  localparam logic [15:0] C_OVF_H1    = 16'hE001;
  localparam logic [15:0] C_H3        = 16'hA003;
  localparam logic [15:0] C_EMPTY_OVF = 16'h6000;
`else
  localparam logic [15:0] C_OVF_H1    = 16'hC001;
  localparam logic [15:0] C_H3        = 16'h8003;
  localparam logic [15:0] C_EMPTY_OVF = 16'h4000;
`endif

  logic [15:0] exp_drain [8];

  dn_spi_tx #(
    .DW          (13),
    .DEPTH       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .dn       (dn),
    .dn_vld   (dn_vld),
    .sck      (sck),
    .cs       (cs),
    .miso     (miso),
    .fifo_cnt (fifo_cnt),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [12:0] v);
    @(negedge clk);
    dn     = v;
    dn_vld = 1'b1;
    @(negedge clk);
    dn_vld = 1'b0;
  endtask

  // One chip-select window of nbits sck pulses (16 clk per sck period).
  task automatic spi_frame(input int nbits, input bit push_at_load, input logic [12:0] load_val,
                           output logic [15:0] word, output logic [3:0] cnt_pre,
                           output logic [3:0] cnt_post, output logic miso_pre,
                           output logic miso_post);
    word = '0;
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cnt_pre = fifo_cnt;
    if (push_at_load) begin
      dn     = load_val;
      dn_vld = 1'b1;
    end
    @(negedge clk);
    dn_vld   = 1'b0;
    cnt_post = fifo_cnt;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      word = {word[14:0], miso};
      sck  = 1'b1;
      repeat (8) @(negedge clk);
      sck  = 1'b0;
      repeat (8) @(negedge clk);
    end
    cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    miso_pre = miso;
    @(negedge clk);
    miso_post = miso;
    repeat (8) @(negedge clk);
  endtask

  logic [15:0] w;
  logic [3:0]  c0, c1;
  logic        m0, m1;

  initial begin
    n_pass  = 0;
    n_total = 0;
`ifdef DN_SPI_TX_PARITY_EN
    exp_drain = '{16'h8004, 16'hA005, 16'hA006, 16'h8007,
                  16'h8008, 16'hA009, 16'hA00A, 16'h800B};
`else
    exp_drain = '{16'h8004, 16'h8005, 16'h8006, 16'h8007,
                  16'h8008, 16'h8009, 16'h800A, 16'h800B};
`endif
    rstn   = 1'b0;
    cs     = 1'b1;
    sck    = 1'b0;
    dn     = '0;
    dn_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_miso", 32'(miso), 32'h0);
    check("reset_cnt", 32'(fifo_cnt), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Single sample, full frame, pop latency.
    push(13'h0ABC);
    check("push1_cnt", 32'(fifo_cnt), 32'h1);
    spi_frame(16, 1'b0, '0, w, c0, c1, m0, m1);
    check("f1_word", 32'(w), 32'h8ABC);
    check("f1_cnt_pre", 32'(c0), 32'h1);
    check("f1_cnt_post", 32'(c1), 32'h0);
    check("f1_miso_done", 32'(m0), 32'h0);

    // Empty FIFO frame.
    spi_frame(16, 1'b0, '0, w, c0, c1, m0, m1);
    check("empty_word", 32'(w), 32'h0000);
    check("empty_cnt", 32'(c1), 32'h0);

    // Abort after 5 sck falls: miso held a 1 (frame bit 10) until abort.
    push(13'h0400);
    push(13'h0055);
    spi_frame(5, 1'b0, '0, w, c0, c1, m0, m1);
    check("abort_bits", 32'(w), 32'h10);
    check("abort_miso_before", 32'(m0), 32'h1);
    check("abort_miso_after", 32'(m1), 32'h0);
    check("abort_ovf", 32'(ovf), 32'h1);
    check("abort_cnt", 32'(fifo_cnt), 32'h1);
    spi_frame(16, 1'b0, '0, w, c0, c1, m0, m1);
    check("post_abort_word", 32'(w), 32'hC055);
    check("post_abort_ovf", 32'(ovf), 32'h0);

    // Overflow: nine pushes into an eight-entry FIFO.
    for (int i = 1; i <= 9; i++) push(13'(i));
    check("ovf_cnt", 32'(fifo_cnt), 32'h8);
    check("ovf_flag", 32'(ovf), 32'h1);
    spi_frame(16, 1'b0, '0, w, c0, c1, m0, m1);
    check("ovf_frame", 32'(w), 32'(C_OVF_H1));
    check("ovf_cleared", 32'(ovf), 32'h0);
    spi_frame(16, 1'b0, '0, w, c0, c1, m0, m1);
    check("frame_0002", 32'(w), 32'h8002);
    check("cnt_after_two", 32'(fifo_cnt), 32'h6);

    // Push and pop together while full.
    push(13'h0009);
    push(13'h000A);
    check("refill_cnt", 32'(fifo_cnt), 32'h8);
    spi_frame(16, 1'b1, 13'h000B, w, c0, c1, m0, m1);
    check("pp_word", 32'(w), 32'(C_H3));
    check("pp_cnt_pre", 32'(c0), 32'h8);
    check("pp_cnt_post", 32'(c1), 32'h8);
    check("pp_ovf", 32'(ovf), 32'h0);
    for (int i = 0; i < 8; i++) begin
      spi_frame(16, 1'b0, '0, w, c0, c1, m0, m1);
      check($sformatf("drain%0d", i), 32'(w), 32'(exp_drain[i]));
    end
    check("drain_cnt", 32'(fifo_cnt), 32'h0);
    check("drain_ovf", 32'(ovf), 32'h0);

    // Abort on an empty frame still flags ovf; next empty frame reports it.
    spi_frame(5, 1'b0, '0, w, c0, c1, m0, m1);
    check("empty_abort_ovf", 32'(ovf), 32'h1);
    spi_frame(16, 1'b0, '0, w, c0, c1, m0, m1);
    check("empty_ovf_word", 32'(w), 32'(C_EMPTY_OVF));
    check("empty_ovf_cleared", 32'(ovf), 32'h0);

    // Asynchronous reset in the middle of a frame.
    push(13'h0111);
    push(13'h0222);
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_frame_miso", 32'(miso), 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("arst_cnt", 32'(fifo_cnt), 32'h0);
    check("arst_miso", 32'(miso), 32'h0);
    check("arst_ovf", 32'(ovf), 32'h0);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    spi_frame(16, 1'b0, '0, w, c0, c1, m0, m1);
    check("arst_empty_word", 32'(w), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
